// File: rtl/systolic_pkg.sv
// Shared constants and helpers for the 4x4 output-stationary systolic multiplier.
package systolic_pkg;

    localparam int N = 4;
    // Edge on which the last A/B pair reaches PE(N-1,N-1): 3*(N-1).
    localparam logic [3:0] LAST_EDGE = 4'd9;

    function automatic int res_idx(input int r, input int c);
        return N * r + c;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: accumulates left*up in place and forwards both operands.
module systolic_pe #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  freeze,
    input  logic [DATA_WIDTH-1:0] left_in,
    input  logic [DATA_WIDTH-1:0] up_in,
    output logic [DATA_WIDTH-1:0] right_out,
    output logic [DATA_WIDTH-1:0] down_out,
    output logic [DATA_WIDTH-1:0] acc_o
);

    // Product is truncated to the operand width; the accumulator wraps.
    logic [DATA_WIDTH-1:0] prod;
    assign prod = left_in * up_in;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_o     <= '0;
            right_out <= '0;
            down_out  <= '0;
        end else if (!freeze) begin
            acc_o     <= acc_o + prod;
            right_out <= left_in;
            down_out  <= up_in;
        end
    end

endmodule

// File: rtl/systolic_mul.sv
// 4x4 systolic matrix multiplier C = A x B with pre-skewed edge feeds and sticky done.
module systolic_mul
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [DATA_WIDTH-1:0]        left_i_0,
    input  logic [DATA_WIDTH-1:0]        left_i_4,
    input  logic [DATA_WIDTH-1:0]        left_i_8,
    input  logic [DATA_WIDTH-1:0]        left_i_12,
    input  logic [DATA_WIDTH-1:0]        up_i_0,
    input  logic [DATA_WIDTH-1:0]        up_i_1,
    input  logic [DATA_WIDTH-1:0]        up_i_2,
    input  logic [DATA_WIDTH-1:0]        up_i_3,
    output logic                         done,
    output logic [N*N*DATA_WIDTH-1:0]    res_o
);

    // h[r][c] feeds PE(r,c) from the left; v[r][c] feeds it from above.
    // Column N of h and row N of v are the grid's far edges and go nowhere.
    logic [DATA_WIDTH-1:0] h   [N][N+1];
    logic [DATA_WIDTH-1:0] v   [N+1][N];
    logic [DATA_WIDTH-1:0] acc [N][N];
    logic [3:0]            cnt;
    logic                  unused_edges;

    assign h[0][0] = left_i_0;
    assign h[1][0] = left_i_4;
    assign h[2][0] = left_i_8;
    assign h[3][0] = left_i_12;
    assign v[0][0] = up_i_0;
    assign v[0][1] = up_i_1;
    assign v[0][2] = up_i_2;
    assign v[0][3] = up_i_3;

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            localparam int IDX = res_idx(r, c);

            systolic_pe #(.DATA_WIDTH(DATA_WIDTH)) u_pe (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .freeze    (done),
                .left_in   (h[r][c]),
                .up_in     (v[r][c]),
                .right_out (h[r][c+1]),
                .down_out  (v[r+1][c]),
                .acc_o     (acc[r][c])
            );

            assign res_o[IDX*DATA_WIDTH +: DATA_WIDTH] = acc[r][c];
        end
    end

    always_comb begin
        unused_edges = 1'b0;
        for (int i = 0; i < N; i++) begin
            unused_edges = unused_edges ^ (^h[i][N]) ^ (^v[N][i]);
        end
    end

    // Counter runs until the last pair has been accumulated, then everything freezes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (!done) begin
            cnt <= cnt + 4'd1;
            if (cnt == LAST_EDGE) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_systolic_mul.sv
// Directed bench for systolic_mul: matrix-product model plus literal spot checks.
module tb_systolic_mul;

    localparam int DW = 32;
    localparam int N  = 4;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic [DW-1:0]      lft [N];
    logic [DW-1:0]      up  [N];
    logic               done;
    logic [N*N*DW-1:0]  res;

    logic [DW-1:0] ma    [N][N];
    logic [DW-1:0] mb    [N][N];
    logic [DW-1:0] exp_c [N][N];

    int  n_vec = 0;
    int  n_err = 0;
    int  kcnt  = 0;
    bit  last_rst = 1'b0;
    bit  active   = 1'b0;

    systolic_mul #(.DATA_WIDTH(DW)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .left_i_0  (lft[0]),
        .left_i_4  (lft[1]),
        .left_i_8  (lft[2]),
        .left_i_12 (lft[3]),
        .up_i_0    (up[0]),
        .up_i_1    (up[1]),
        .up_i_2    (up[2]),
        .up_i_3    (up[3]),
        .done      (done),
        .res_o     (res)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Edges counted since the last sampled reset.
    always @(posedge clk_i) begin
        if (rst_i) begin
            kcnt     <= 0;
            last_rst <= 1'b1;
            active   <= 1'b1;
        end else begin
            kcnt     <= (kcnt < 1000) ? kcnt + 1 : kcnt;
            last_rst <= 1'b0;
        end
    end

    function automatic logic [DW-1:0] res_at(input int r, input int c);
        return res[(N*r+c)*DW +: DW];
    endfunction

    always @(negedge clk_i) begin
        if (active) begin
            if (last_rst) begin
                n_vec++;
                if (done !== 1'b0 || res !== '0) begin
                    n_err++;
                    $display("FAIL reset_state: done=%b res_nonzero=%b, want done=0 res=0",
                             done, (res !== '0));
                end
            end else begin
                n_vec++;
                if (done !== (kcnt >= 10)) begin
                    n_err++;
                    $display("FAIL done_timing: edges=%0d done=%b want %b", kcnt, done, (kcnt >= 10));
                end
                if (kcnt >= 10) begin
                    for (int r = 0; r < N; r++) begin
                        for (int c = 0; c < N; c++) begin
                            n_vec++;
                            if (res_at(r, c) !== exp_c[r][c]) begin
                                n_err++;
                                $display("FAIL c%0d%0d: got %h want %h", r, c, res_at(r, c), exp_c[r][c]);
                            end
                        end
                    end
                end
            end
        end
    end

    // Plain matrix product, each product and the running sum taken mod 2^DW.
    task automatic compute_model();
        longint unsigned sum, mask;
        mask = (64'd1 << DW) - 64'd1;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                sum = 0;
                for (int j = 0; j < N; j++) begin
                    sum = (sum + ((longint'(ma[r][j]) * longint'(mb[j][c])) & mask)) & mask;
                end
                exp_c[r][c] = DW'(sum);
            end
        end
    endtask

    task automatic drive_edge(input int k);
        for (int i = 0; i < N; i++) begin
            lft[i] = (k - i >= 0 && k - i < N) ? ma[i][k-i] : '0;
            up[i]  = (k - i >= 0 && k - i < N) ? mb[k-i][i] : '0;
        end
    endtask

    task automatic zero_inputs();
        for (int i = 0; i < N; i++) begin
            lft[i] = '0;
            up[i]  = '0;
        end
    endtask

    task automatic junk_inputs();
        for (int i = 0; i < N; i++) begin
            lft[i] = $urandom() | 32'h1;
            up[i]  = $urandom() | 32'h1;
        end
    endtask

    // Reset, then feed edges 0..stop_k-1; if stop_k < 10, reset lands on edge stop_k.
    task automatic run(input int stop_k, input bit junk);
        rst_i = 1'b1;
        zero_inputs();
        @(posedge clk_i);
        compute_model();
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int k = 0; k < stop_k; k++) begin
            drive_edge(k);
            @(negedge clk_i);
        end
        if (stop_k < 10) begin
            rst_i = 1'b1;
            drive_edge(stop_k);
            @(negedge clk_i);
        end else begin
            for (int t = 0; t < 5; t++) begin
                if (junk) junk_inputs();
                else zero_inputs();
                @(negedge clk_i);
            end
        end
    endtask

    task automatic check_lit(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic load_standard();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                ma[r][c] = DW'(N*r + c + 1);
                mb[r][c] = DW'(c + 1);
            end
        end
    endtask

    initial begin
        zero_inputs();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                ma[r][c] = '0;
                mb[r][c] = '0;
                exp_c[r][c] = '0;
            end
        end
        repeat (2) @(negedge clk_i);

        // Standard product, with junk on inputs after done.
        load_standard();
        run(10, 1'b1);
        check_lit("std_c00", res_at(0, 0), 32'd10);
        check_lit("std_c03", res_at(0, 3), 32'd40);
        check_lit("std_c12", res_at(1, 2), 32'd78);
        check_lit("std_c21", res_at(2, 1), 32'd84);
        check_lit("std_c33", res_at(3, 3), 32'd232);
        check_lit("std_done", {31'd0, done}, 32'd1);

        // Identity times 1..16.
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                ma[r][c] = (r == c) ? 32'd1 : 32'd0;
                mb[r][c] = DW'(N*r + c + 1);
            end
        end
        run(10, 1'b1);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                check_lit("ident", res_at(r, c), DW'(N*r + c + 1));
            end
        end

        // Mid-run reset at edge 5, then the standard product again.
        load_standard();
        run(5, 1'b0);
        run(10, 1'b0);
        check_lit("rerun_c33", res_at(3, 3), 32'd232);
        check_lit("rerun_c10", res_at(1, 0), 32'd26);

        // Reset on edge 9 wins over done.
        run(9, 1'b0);
        check_lit("rst_edge9_done", {31'd0, done}, 32'd0);

        // Wraparound: 0x10000 squared truncates to zero.
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                ma[r][c] = '0;
                mb[r][c] = '0;
            end
        end
        ma[0][0] = 32'h0001_0000;
        mb[0][0] = 32'h0001_0000;
        run(10, 1'b0);
        check_lit("wrap_c00", res_at(0, 0), 32'd0);
        check_lit("wrap_all", {31'd0, (res == '0)}, 32'd1);

        // Wrap of a nonzero result: 0x10001 squared = 0x1_0002_0001 -> 0x0002_0001.
        ma[0][0] = 32'h0001_0001;
        mb[0][0] = 32'h0001_0001;
        run(10, 1'b0);
        check_lit("wrap2_c00", res_at(0, 0), 32'h0002_0001);
        check_lit("wrap2_c01", res_at(0, 1), 32'd0);

        // All-zero operands.
        ma[0][0] = '0;
        mb[0][0] = '0;
        run(10, 1'b1);
        check_lit("zero_done", {31'd0, done}, 32'd1);
        check_lit("zero_res", {31'd0, (res == '0)}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
